// File: rtl/mmcm_drp_pkg.sv
// Shared types for the MMCM divide sequencer: counter field struct, range limits, FSM states.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package mmcm_drp_pkg;

    // Legal integer range for any MMCM counter.
    localparam logic [6:0] MIN_DIV      = 7'd1;
    localparam logic [6:0] MAX_DIV      = 7'd64;
    // A fractional counter needs a whole integer part on both sides of the phase step.
    localparam logic [6:0] FRAC_MIN_DIV = 7'd2;
    localparam logic [6:0] FRAC_MAX_DIV = 7'd63;

    // One MMCME2 counter in DRP-field form.
    typedef struct packed {
        logic [5:0] high_time;
        logic [5:0] low_time;
        logic       edge_bit;
        logic       no_count;
        logic [2:0] frac;
        logic       frac_en;
        logic       wf_r;
    } counter_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_RDY,
        ST_START,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_RESP
    } seq_state_t;

    // Integer-only encoding. Divide-by-1 bypasses the counter; 64 splits evenly to 32/32.
    function automatic counter_fields_t int_fields(input logic [6:0] d);
        counter_fields_t f;
        logic [6:0]      hi;
        f  = '0;
        hi = {1'b0, d[6:1]};
        if (d == 7'd1) begin
            f.high_time = 6'd1;
            f.low_time  = 6'd1;
            f.no_count  = 1'b1;
        end else begin
            f.high_time = hi[5:0];
            f.low_time  = 6'(d - hi);
            f.edge_bit  = d[0];
        end
        return f;
    endfunction

endpackage

// File: rtl/mmcm_count_calc.sv
// Divide value (integer + eighths) to MMCME2 counter fields, with range check. Fractional path under MMCM_FRAC_DIV_EN.
// Latency: purely combinational.
// Backpressure: none; caller registers the result when it wants it.
module mmcm_count_calc
    import mmcm_drp_pkg::*;
(
    input  logic [6:0]      div_int,
    input  logic [2:0]      div_frac,
    output counter_fields_t fields,
    output logic            range_err
);

`ifdef MMCM_FRAC_DIV_EN
    logic [3:0] oaf;
    logic [5:0] half;

    // Odd-and-fraction: eighths left over beyond the even half-periods.
    assign oaf  = {div_int[0], 3'b000} + {1'b0, div_frac};
    assign half = div_int[6:1];
`endif

    // Integer encoding by default; a nonzero fraction either switches to the fractional form or is rejected.
    always_comb begin
        fields    = int_fields(div_int);
        range_err = (div_int < MIN_DIV) || (div_int > MAX_DIV);
        if (div_frac != 3'd0) begin
`ifdef MMCM_FRAC_DIV_EN
            range_err        = (div_int < FRAC_MIN_DIV) || (div_int > FRAC_MAX_DIV);
            fields.high_time = half - {5'd0, (oaf <= 4'd8)};
            fields.low_time  = half - {5'd0, (oaf <= 4'd9)};
            fields.edge_bit  = 1'b0;
            fields.no_count  = 1'b0;
            fields.frac      = div_frac;
            fields.frac_en   = 1'b1;
            fields.wf_r      = (oaf >= 4'd1) && (oaf <= 4'd8);
`else
            range_err = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mmcm_divide_sequencer.sv
// Sequences one MMCM divide/multiply change: encode, hold fields, kick DRP engine, wait done+lock, respond ok/err. Optional MMCM_FRAC_DIV_EN enables fractional out0/fb.
// Latency: range error responds 2 cycles after accept; otherwise gated by reconfig_ready, reconfig_done and lock (bounded by LOCK_TIMEOUT).
// Backpressure: req_ready high only when idle; requests while busy are dropped, nothing is queued.
module mmcm_divide_sequencer
    import mmcm_drp_pkg::*;
#(
    parameter int INIT_OUT0_DIV = 20,
    parameter int INIT_FB_MULT  = 20,
    parameter int INIT_DIVCLK   = 1,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_out0_div,
    input  logic [9:0] req_fb_mult,
    input  logic [6:0] req_divclk,
    output logic       resp_valid,
    output logic       resp_err,
    output logic       busy,
    output logic [5:0] out0_high_time,
    output logic [5:0] out0_low_time,
    output logic       out0_edge,
    output logic       out0_no_count,
    output logic [2:0] out0_frac,
    output logic       out0_frac_en,
    output logic       out0_wf_r,
    output logic [5:0] fb_high_time,
    output logic [5:0] fb_low_time,
    output logic       fb_edge,
    output logic       fb_no_count,
    output logic [2:0] fb_frac,
    output logic       fb_frac_en,
    output logic       fb_wf_r,
    output logic [5:0] div_high_time,
    output logic [5:0] div_low_time,
    output logic       div_edge,
    output logic       div_no_count,
    output logic       start_reconfig,
    input  logic       reconfig_ready,
    input  logic       reconfig_done,
    input  logic       mmcm_locked
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    localparam counter_fields_t OUT0_INIT = int_fields(7'(INIT_OUT0_DIV));
    localparam counter_fields_t FB_INIT   = int_fields(7'(INIT_FB_MULT));
    localparam counter_fields_t DIV_INIT  = int_fields(7'(INIT_DIVCLK));

    seq_state_t      state, state_nxt;
    logic [9:0]      out0_req, fb_req;
    logic [6:0]      div_req;
    counter_fields_t out0_calc, fb_calc, div_calc;
    logic            out0_err, fb_err, div_range_err, div_err, any_err;
    counter_fields_t out0_q, fb_q;
    logic            err_q;
    logic [CNT_W-1:0] lock_cnt;

    mmcm_count_calc u_out0_calc (
        .div_int   (out0_req[9:3]),
        .div_frac  (out0_req[2:0]),
        .fields    (out0_calc),
        .range_err (out0_err)
    );

    mmcm_count_calc u_fb_calc (
        .div_int   (fb_req[9:3]),
        .div_frac  (fb_req[2:0]),
        .fields    (fb_calc),
        .range_err (fb_err)
    );

    mmcm_count_calc u_div_calc (
        .div_int   (div_req),
        .div_frac  (3'd0),
        .fields    (div_calc),
        .range_err (div_range_err)
    );

    // DIVCLK has no fractional stage, so any fractional encoding on it counts as a range error.
    assign div_err = div_range_err | div_calc.frac_en | div_calc.wf_r | (|div_calc.frac);
    assign any_err = out0_err | fb_err | div_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; handshakes are only honoured in the state that waits for them.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (req_valid) state_nxt = ST_CALC;
            ST_CALC:      state_nxt = any_err ? ST_RESP : ST_WAIT_RDY;
            ST_WAIT_RDY:  if (reconfig_ready) state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (reconfig_done) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (mmcm_locked || lock_cnt == LOCK_LAST) state_nxt = ST_RESP;
            ST_RESP:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, field update in CALC only, error flag and lock timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_req      <= '0;
            fb_req        <= '0;
            div_req       <= '0;
            out0_q        <= OUT0_INIT;
            fb_q          <= FB_INIT;
            div_high_time <= DIV_INIT.high_time;
            div_low_time  <= DIV_INIT.low_time;
            div_edge      <= DIV_INIT.edge_bit;
            div_no_count  <= DIV_INIT.no_count;
            err_q         <= 1'b0;
            lock_cnt      <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                out0_req <= req_out0_div;
                fb_req   <= req_fb_mult;
                div_req  <= req_divclk;
            end
            if (state == ST_CALC) begin
                err_q <= any_err;
                if (!any_err) begin
                    out0_q        <= out0_calc;
                    fb_q          <= fb_calc;
                    div_high_time <= div_calc.high_time;
                    div_low_time  <= div_calc.low_time;
                    div_edge      <= div_calc.edge_bit;
                    div_no_count  <= div_calc.no_count;
                end
            end
            if (state == ST_WAIT_DONE && reconfig_done) lock_cnt <= '0;
            if (state == ST_WAIT_LOCK) begin
                lock_cnt <= lock_cnt + 1'b1;
                if (!mmcm_locked && lock_cnt == LOCK_LAST) err_q <= 1'b1;
            end
        end
    end

    assign req_ready      = (state == ST_IDLE);
    assign busy           = ~req_ready;
    assign start_reconfig = (state == ST_START);
    assign resp_valid     = (state == ST_RESP);
    assign resp_err       = resp_valid & err_q;

    assign out0_high_time = out0_q.high_time;
    assign out0_low_time  = out0_q.low_time;
    assign out0_edge      = out0_q.edge_bit;
    assign out0_no_count  = out0_q.no_count;
    assign out0_frac      = out0_q.frac;
    assign out0_frac_en   = out0_q.frac_en;
    assign out0_wf_r      = out0_q.wf_r;
    assign fb_high_time   = fb_q.high_time;
    assign fb_low_time    = fb_q.low_time;
    assign fb_edge        = fb_q.edge_bit;
    assign fb_no_count    = fb_q.no_count;
    assign fb_frac        = fb_q.frac;
    assign fb_frac_en     = fb_q.frac_en;
    assign fb_wf_r        = fb_q.wf_r;

endmodule
